// File: rtl/ppu_pkg.sv
// Shared types and widths for the post-processing sequencer and its byte packer.
package ppu_pkg;
    localparam int PPU_DATA_W     = 32;
    localparam int PPU_OUT_W      = 8;
    localparam int PPU_SCALE_W    = 6;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FLUSH, DONE} ppu_ctrl_state_e;

    // Byte enables for a partial word holding n bytes in the low lanes.
    function automatic logic [BYTES_PER_WORD-1:0] lane_strb(input logic [LANE_W-1:0] n);
        return (BYTES_PER_WORD'(1) << n) - BYTES_PER_WORD'(1);
    endfunction
endpackage

// File: rtl/ppu_ctrl_byte_packer.sv
// Collects PPU result bytes into words; emits a registered write on a full word
// or, on flush, a zero-padded partial word with matching byte enables.
module byte_packer
    import ppu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic                      valid_i,
    input  logic [PPU_OUT_W-1:0]      byte_i,
    input  logic                      flush_i,
    output logic                      we_o,
    output logic [PPU_DATA_W-1:0]     wdata_o,
    output logic [BYTES_PER_WORD-1:0] wstrb_o
);
    logic [LANE_W-1:0]         lane_q, lane_d;
    logic [PPU_DATA_W-1:0]     word_q, word_d;
    logic                      we_q, we_d;
    logic [PPU_DATA_W-1:0]     wdata_q, wdata_d;
    logic [BYTES_PER_WORD-1:0] wstrb_q, wstrb_d;

    always_comb begin
        lane_d  = lane_q;
        word_d  = word_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (valid_i) begin
            word_d[int'(lane_q)*PPU_OUT_W +: PPU_OUT_W] = byte_i;
            lane_d = lane_q + LANE_W'(1);
        end
        // Flush includes a byte arriving in the same cycle, so the tail write
        // lands right after the last result just like a full-word write.
        if (valid_i && lane_q == LANE_W'(BYTES_PER_WORD-1)) begin
            we_d    = 1'b1;
            wdata_d = word_d;
            wstrb_d = '1;
            word_d  = '0;
        end else if (flush_i && lane_d != '0) begin
            we_d    = 1'b1;
            wdata_d = word_d;
            wstrb_d = lane_strb(lane_d);
            word_d  = '0;
            lane_d  = '0;
        end
        if (clr_i) begin
            lane_d = '0;
            word_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            lane_q  <= lane_d;
            word_q  <= word_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign we_o    = we_q;
    assign wdata_o = wdata_q;
    assign wstrb_o = wstrb_q;
endmodule

// File: rtl/ppu_ctrl.sv
// Streams a tile of partial sums from the PSUM buffer through the PPU and packs
// the 8-bit results four-per-word into the output activation buffer.
module ppu_ctrl
    import ppu_pkg::*;
#(
    parameter int PSUM_AW = 10,
    parameter int OUT_AW  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [PSUM_AW:0]          num_psum,
    input  logic [PSUM_AW-1:0]        psum_base,
    input  logic [OUT_AW-1:0]         out_base,
    input  logic [PPU_SCALE_W-1:0]    scale_in,
    output logic                      busy,
    output logic                      done,
    output logic                      psum_rd_en,
    output logic [PSUM_AW-1:0]        psum_rd_addr,
    input  logic [PPU_DATA_W-1:0]     psum_rdata,
    output logic                      ppu_en,
    output logic [PPU_DATA_W-1:0]     ppu_data,
    output logic [PPU_SCALE_W-1:0]    ppu_scale,
    input  logic                      ppu_valid,
    input  logic [PPU_OUT_W-1:0]      ppu_out,
    output logic                      ob_we,
    output logic [OUT_AW-1:0]         ob_addr,
    output logic [PPU_DATA_W-1:0]     ob_wdata,
    output logic [BYTES_PER_WORD-1:0] ob_wstrb
);
    localparam int CW = PSUM_AW + 1;

    ppu_ctrl_state_e         state_q, state_d;
    logic [PSUM_AW-1:0]      rd_addr_q, rd_addr_d;
    logic [CW-1:0]           rem_q, rem_d;
    logic [CW-1:0]           inflight_q, inflight_d;
    logic [OUT_AW-1:0]       ob_addr_q, ob_addr_d;
    logic [PPU_SCALE_W-1:0]  scale_q, scale_d;
    logic                    ppu_en_q;
    logic                    vld_in, flush, clr;

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign psum_rd_en   = (state_q == ISSUE);
    assign psum_rd_addr = rd_addr_q;
    assign ppu_en       = ppu_en_q;
    assign ppu_data     = ppu_en_q ? psum_rdata : '0;
    assign ppu_scale    = scale_q;
    assign ob_addr      = ob_addr_q;
    assign vld_in       = ppu_valid && busy;
    assign clr          = (state_q == DONE);

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        rem_d      = rem_q;
        ob_addr_d  = ob_addr_q;
        scale_d    = scale_q;
        inflight_d = inflight_q + CW'(psum_rd_en) - CW'(vld_in);
        flush      = 1'b0;
        if (ob_we) ob_addr_d = ob_addr_q + OUT_AW'(1);
        case (state_q)
            IDLE: if (start) begin
                rd_addr_d = psum_base;
                rem_d     = num_psum;
                ob_addr_d = out_base;
                scale_d   = scale_in;
                state_d   = (num_psum == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                rd_addr_d = rd_addr_q + PSUM_AW'(1);
                rem_d     = rem_q - CW'(1);
                if (rem_q == CW'(1)) state_d = DRAIN;
            end
            // Leave as the last result arrives so the tail write is not delayed.
            DRAIN: if (inflight_d == '0) begin
                flush   = 1'b1;
                state_d = FLUSH;
            end
            FLUSH: state_d = DONE;
            DONE: begin
                state_d    = IDLE;
                rd_addr_d  = '0;
                ob_addr_d  = '0;
                rem_d      = '0;
                inflight_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            rem_q      <= '0;
            inflight_q <= '0;
            ob_addr_q  <= '0;
            scale_q    <= '0;
            ppu_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            ob_addr_q  <= ob_addr_d;
            scale_q    <= scale_d;
            ppu_en_q   <= psum_rd_en;
        end
    end

    byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .valid_i (vld_in),
        .byte_i  (ppu_out),
        .flush_i (flush),
        .we_o    (ob_we),
        .wdata_o (ob_wdata),
        .wstrb_o (ob_wstrb)
    );
endmodule

// File: doc/ppu_ctrl.md
# ppu_ctrl

Sequencer that streams N 32-bit partial sums from the PSUM buffer through the post-processing unit (ReLU + shift + uint8 requantize, registered, 1-cycle latency) and packs the 8-bit results four-per-word into the output activation buffer. It sits between the PE-array accumulation buffer and the output SRAM. It is started once per output tile by the layer controller and reports completion with a `done` pulse.

## Interface
- `PSUM_AW`, 10, PSUM buffer address width
- `OUT_AW`, 8, output buffer word-address width
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `num_psum`  in  PSUM_AW+1  number of partial sums to process (0..2^PSUM_AW)
- `psum_base`  in  PSUM_AW  first PSUM address
- `out_base`  in  OUT_AW  first output word address
- `scale_in`  in  6  right-shift amount, latched at start
- `busy`  out  1  high from accepted start until done
- `done`  out  1  one-cycle completion pulse
- `psum_rd_en`  out  1  PSUM read strobe; read data returns the next cycle
- `psum_rd_addr`  out  PSUM_AW  PSUM read address
- `psum_rdata`  in  32  PSUM read data
- `ppu_en`  out  1  drives PPU `i_en`
- `ppu_data`  out  32  drives PPU `data_in`
- `ppu_scale`  out  6  drives PPU `scaling_factor`; constant while busy
- `ppu_valid`  in  1  PPU `valid`
- `ppu_out`  in  8  PPU `data_out`
- `ob_we`  out  1  output buffer write strobe
- `ob_addr`  out  OUT_AW  output word address
- `ob_wdata`  out  32  packed bytes; byte k in bits [8k+7:8k]
- `ob_wstrb`  out  4  byte enables

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FLUSH, DONE.
- IDLE: on `start`, latch `num_psum`, `psum_base`, `out_base`, and `scale_in`. Go to ISSUE, or to DONE if `num_psum`==0. `start` in any other state is ignored.
- ISSUE: assert `psum_rd_en` with address psum_base+i for i=0..N-1, one per cycle, no gaps. The address wraps modulo 2^PSUM_AW. After the last read, go to DRAIN.
- Pass-through: `ppu_en` = `psum_rd_en` delayed one cycle. `ppu_data` = `psum_rdata`, combinational.
- Packer: each cycle with `ppu_valid`=1, place `ppu_out` into byte lane `lane` (0..3), then increment `lane`. When lane 3 fills, a registered write is issued the next cycle: full word, `ob_wstrb`=4'b1111. `ob_addr` then increments, wrapping modulo 2^OUT_AW.
- DRAIN: wait until the in-flight count reaches 0, i.e. the number of reads issued minus PPU results received.
- FLUSH: if `lane`≠0, write the partial word. Unused lanes are zero, and `ob_wstrb` has the low `lane` bits set. Then go to DONE.
- DONE: `done`=1 for one cycle, `busy` falls, return to IDLE. Lane and address state are cleared.
- `ppu_valid` outside busy is ignored.
- Reset, asynchronous and possibly mid-operation: go to IDLE immediately. All outputs take their reset values below, and any partial word is discarded.

## Timing
- Reset values: `busy`, `done`, `psum_rd_en`, `ppu_en`, `ob_we` = 0. `psum_rd_addr`, `ppu_data` (when `ppu_en`=0), `ob_addr`, `ob_wdata` = 0. `ob_wstrb` = 0. `ppu_scale` = 0.
- Cycle numbering: `start` is sampled at cycle 0.
  - `busy` is high from cycle 1.
  - Reads occur in cycles 1..N.
  - `ppu_en` is high in cycles 2..N+1.
  - `ppu_valid` is high in cycles 3..N+2.
- Full-word writes happen at cycle 3+4k+4, for k=0,1,...
- Final write: at cycle N+3. When N%4==0 it is the last full-word write; otherwise it is the FLUSH write.
- `done` at cycle N+4. For N=0, `done` at cycle 1 with no reads and no writes.
- Throughput: one partial sum per cycle, sustained. `ob_we` never asserts on two consecutive cycles.

## Structure
- Shared package `ppu_pkg`:
  - FSM state enum `ppu_ctrl_state_e`.
  - `PPU_DATA_W`=32, `PPU_OUT_W`=8, `PPU_SCALE_W`=6, `BYTES_PER_WORD`=4.
- One natural sub-module: `byte_packer`. It covers lane counter, word register, write strobe generation, and flush. The FSM and address counters stay in `ppu_ctrl`.
- The PPU itself is instantiated by the parent, not inside this block.

## Test plan
- N=4, scale=0, psum 0, 1, 127, -5 with the real PPU model -> one write at cycle 7: addr=out_base, wdata=0x80FF8180, wstrb=4'hF. `done` at cycle 8.
- N=6, scale=2, psum all 400 (400>>2=100, 100^128=228) -> writes at cycle 7 with 0xE4E4E4E4/4'hF and at cycle 9 with 0x0000E4E4/4'h3. `done` at cycle 10.
- N=0 -> `done` at cycle 1, no `psum_rd_en` or `ob_we`. A second `start` asserted while busy during an N=8 run -> ignored; exactly two words written.
- Wrap: psum_base=1022, out_base=255, N=8 -> read addresses 1022, 1023, 0..5. Writes go to 255 then 0.
- Reset asserted at cycle 4 of an N=8 run -> all outputs 0 asynchronously, no `ob_we`. A new `start` after reset runs normally.
- Saturation: psum 200, scale=0 (200^128=72, MSB 0) -> byte 0xFF.
